// File: rtl/lcd_cmd_issuer.sv
// Host-side command source for the LCD controller: FIFO-buffered, busy/done-paced issue.
// Optional build macro LCD_CMD_CHECK_EN: reject codes 0xC-0xF at the input and count them in err_cnt.
module lcd_cmd_issuer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic                     frame_done,
  output logic [7:0]               err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, SENT, GUARD, WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       mem_q [DEPTH];
  logic [3:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [AW:0]      level;
  logic             full, empty, accept, push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level  = wr_ptr_q - rd_ptr_q;
  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign accept = in_valid && !full;

`ifdef LCD_CMD_CHECK_EN
  logic       legal;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign legal = (in_cmd <= 4'hB);
  assign push  = accept && legal;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && !legal && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign push    = accept;
  assign err_cnt = 8'd0;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    issued_cnt_d = issued_cnt_q;

    if (push)
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);

    case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          cmd_d        = mem_q[rd_ptr_q[AW-1:0]];
          cmd_valid_d  = 1'b1;
          rd_ptr_d     = rd_ptr_q + (AW+1)'(1);
          issued_cnt_d = issued_cnt_q + CNT_W'(1);
          state_d      = SENT;
        end
      end
      // cmd_q still holds the code just issued; a write must wait for done.
      SENT:  state_d = (cmd_q == 4'h0) ? WAIT_DONE : GUARD;
      GUARD: state_d = IDLE;
      WAIT_DONE: begin
        if (done) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cmd_q        <= 4'h0;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      frame_done_q <= frame_done_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  // Storage needs no reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= in_cmd;
  end

  assign in_ready   = !full;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign frame_done = frame_done_q;
  assign issued_cnt = issued_cnt_q;
  assign fifo_level = level;
endmodule

// File: doc/lcd_cmd_issuer.md
# lcd_cmd_issuer

Host-side command source for the LCD controller's `cmd`/`cmd_valid`/`busy`/`done` interface: the driving end of the command handshake. It accepts 4-bit commands from an upstream valid/ready producer and buffers them in a FIFO. It releases them one at a time to the LCD controller, honouring `busy`. After a write command (0x0) it holds off until the controller's `done`.

## Interface
- `DEPTH`, 8 — FIFO entries; power of 2, ≥ 2.
- `CNT_W`, 8 — width of `issued_cnt`.
- `clk` in 1 — clock, all state on posedge.
- `reset` in 1 — reset, asynchronous, active-low.
- `in_cmd` in 4 — upstream command code.
- `in_valid` in 1 — upstream command present.
- `in_ready` out 1 — FIFO not full; combinational, `= !full`.
- `cmd` out 4 — command to LCD controller; registered.
- `cmd_valid` out 1 — command strobe to LCD controller; registered, one-cycle pulse.
- `busy` in 1 — LCD controller busy.
- `done` in 1 — LCD controller finished writing image RAM.
- `fifo_level` out log2(DEPTH)+1 — current FIFO occupancy.
- `issued_cnt` out CNT_W — commands issued, wraps mod 2^CNT_W.
- `frame_done` out 1 — one-cycle pulse after `done` received for a write command.
- `err_cnt` out 8 — rejected illegal codes, saturating at 255; see Configuration.

## Operation
- Push occurs when `in_valid && in_ready` at posedge. Pop occurs only in IDLE on issue. Simultaneous push and pop leave `fifo_level` unchanged.
- The FSM has four states: IDLE, SENT, GUARD and WAIT_DONE.
- IDLE:
  - If FIFO is non-empty and `busy`=0: `cmd`<=head, `cmd_valid`<=1, pop, `issued_cnt`++, go to SENT.
  - Otherwise stay in IDLE.
- SENT: `cmd_valid`<=0. If the issued code was 0x0, go to WAIT_DONE; else go to GUARD.
- GUARD: one cycle with no issue, so the controller's `busy` becomes visible. Go to IDLE.
- WAIT_DONE: no issue. On `done`=1, `frame_done`<=1 for one cycle and go to IDLE.
- `done` is ignored outside WAIT_DONE.
- `cmd` holds its last value when `cmd_valid`=0.
- Legal codes are 0x0–0xB: write, shift U/D/L/R, max, min, avg, CCW rotate, CW rotate, mirror X, mirror Y.
- Reset values:
  - `cmd`=0, `cmd_valid`=0, `frame_done`=0.
  - `issued_cnt`=0, `err_cnt`=0, `fifo_level`=0.
  - FIFO pointers are 0, so `in_ready`=1 during reset.
  - State is IDLE.
- Reset mid-operation discards FIFO contents and any pending WAIT_DONE. No `cmd_valid` is emitted until a new push arrives.

## Timing
- Push at edge N into an empty FIFO with `busy`=0 → `cmd_valid` high after edge N+1, low after edge N+2.
- Back-to-back non-write commands with `busy` held 0 issue at most one per 3 cycles (IDLE→SENT→GUARD).
- `busy` is sampled only in IDLE. If `busy`=1, issue waits; there is no timeout.
- `frame_done` rises on the edge after `done` is sampled high in WAIT_DONE.
- When full, `in_ready`=0. If a pop happens in the same cycle, `in_ready` returns to 1 on the next cycle; there is no same-cycle bypass.
- `fifo_level` and `issued_cnt` update on the same edge as the push/pop.

## Configuration
- Macro: `LCD_CMD_CHECK_EN`.
- Defined:
  - Codes 0xC–0xF are consumed at the input and never enter the FIFO.
  - `in_ready` still obeys `!full`.
  - `err_cnt` increments per rejected code, saturating at 255.
- Undefined:
  - All codes are pushed and issued unchanged.
  - `err_cnt` is tied to 0.

## Test plan
- **Reset values:** assert `reset`=0 mid-run with 3 entries queued → all outputs at reset values; `fifo_level`=0; no `cmd_valid` for 10 cycles after release.
- **Paced issue:** push 1,4,9 with `busy`=0 → three `cmd_valid` pulses 3 cycles apart with `cmd`=1,4,9; `issued_cnt`=3.
- **Busy stall:** hold `busy`=1 for 20 cycles with 2 queued → no `cmd_valid`. First pulse comes 1 cycle after `busy` falls.
- **Write and done:** push 0x0 then 0x5 → after the 0x0 pulse, no issue until `done`. Then `frame_done` pulses once and 0x5 issues 1 cycle later.
- **Full FIFO:** push DEPTH+2 codes with `busy`=1 → `in_ready`=0 at `fifo_level`=DEPTH; the extras are held by upstream. All DEPTH entries issue in order once `busy`=0.
- **Illegal codes:** with `LCD_CMD_CHECK_EN` defined, push 0xC, 0x2, 0xF → only 0x2 issued, `err_cnt`=2. Without the macro, all three are issued and `err_cnt`=0.
